// File: rtl/perf_run_ctrl_pkg.sv
// perf_pkg: shared definitions for the run/halt/step sequencer.
//   - run_state_t : 2-bit sequencer state encoding
//   - SEL_*       : display source select codes
//   - defaults for the pass-through syscall code and display source count
//   - sel_advance : wrap-around increment of the display select
package perf_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT      = 2'd1,
        STEP_IDLE = 2'd2,
        STEP_ONE  = 2'd3
    } run_state_t;

    localparam logic [1:0]  SEL_CYCLE     = 2'd0;
    localparam logic [1:0]  SEL_BRANCH    = 2'd1;
    localparam logic [1:0]  SEL_JMP       = 2'd2;

    localparam logic [31:0] PASS_CODE_DEF = 32'd34;
    localparam int          DISP_CNT_DEF  = 3;

    // Next display select: wraps to SEL_CYCLE after the last source.
    function automatic logic [1:0] sel_advance(input logic [1:0] sel,
                                               input logic [1:0] last);
        logic [1:0] nxt;
        if (sel >= last) begin
            nxt = SEL_CYCLE;
        end else begin
            nxt = sel + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/perf_run_ctrl_if.sv
// perf_run_ctrl_if: bundles the decode, button/switch, counter and
// control/display signals of the run controller.
//   master : the surrounding system (decode stage, board I/O, counters)
//   slave  : the run controller itself
interface perf_run_ctrl_if;

    logic        syscall;      // decode: current instruction is syscall
    logic [31:0] R1;           // register examined on syscall
    logic        branch_in;    // decode: taken branch this cycle
    logic        jmp_in;       // decode: jump this cycle
    logic        go;           // resume button (level)
    logic        step_mode;    // single-step switch
    logic        step;         // step button (level)
    logic        sel_next;     // display-advance button (level)
    logic [31:0] count_cycle;  // cycle counter value
    logic [31:0] count_b;      // branch counter value
    logic [31:0] count_j;      // jump counter value
    logic        cpu_en;       // PC/regfile write enable
    logic        cycle_en;     // cycle counter enable
    logic        branch_en;    // branch counter enable
    logic        jmp_en;       // jump counter enable
    logic        halted;       // registered HALT indicator
    logic [1:0]  disp_sel;     // registered display source
    logic [31:0] disp_data;    // registered display value

    modport master (
        output syscall, R1, branch_in, jmp_in, go, step_mode, step, sel_next,
        output count_cycle, count_b, count_j,
        input  cpu_en, cycle_en, branch_en, jmp_en, halted, disp_sel, disp_data
    );

    modport slave (
        input  syscall, R1, branch_in, jmp_in, go, step_mode, step, sel_next,
        input  count_cycle, count_b, count_j,
        output cpu_en, cycle_en, branch_en, jmp_en, halted, disp_sel, disp_data
    );

endinterface

// File: rtl/perf_run_ctrl_edge_pulse.sv
// edge_pulse: one-cycle pulse on a 0->1 transition of a level input.
// The pulse appears the cycle after the input is first sampled high.
// History resets to 1 so a level held through reset yields no pulse.
//   clk      : system clock
//   clr      : asynchronous active-high reset
//   in_level : debounced level input
//   pulse    : registered rising-edge pulse
module edge_pulse (
    input  logic clk,
    input  logic clr,
    input  logic in_level,
    output logic pulse
);

    logic hist_r;
    logic pulse_r;

    // Sample history and form the registered rising-edge pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist_r  <= 1'b1;
            pulse_r <= 1'b0;
        end else begin
            hist_r  <= in_level;
            pulse_r <= in_level & ~hist_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/perf_run_ctrl.sv
// perf_run_ctrl: run/halt/single-step sequencer for the MIPS core and its
// cycle/branch/jump performance counters, plus display source scheduling.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset
//   bus : perf_run_ctrl_if.slave
//         in : syscall, R1, branch_in, jmp_in, go, step_mode, step,
//              sel_next, count_cycle, count_b, count_j
//         out: cpu_en, cycle_en, branch_en, jmp_en (combinational),
//              halted, disp_sel, disp_data (registered)
module perf_run_ctrl
    import perf_pkg::*;
#(
    parameter logic [31:0] PASS_CODE = PASS_CODE_DEF,
    parameter int          DISP_CNT  = DISP_CNT_DEF
) (
    input  logic          clk,
    input  logic          clr,
    perf_run_ctrl_if.slave bus
);

    localparam logic [1:0] DISP_LAST = 2'(DISP_CNT - 1);

    run_state_t  state_r;
    run_state_t  state_nxt_s;
    logic        skip_r;
    logic        skip_nxt_s;
    logic        halted_r;
    logic [1:0]  disp_sel_r;
    logic [31:0] disp_data_r;

    logic        go_p_s;
    logic        step_p_s;
    logic        sel_p_s;
    logic        halt_hit_s;
    logic        exec_s;
    logic        cpu_en_s;

    edge_pulse u_go_edge (
        .clk      (clk),
        .clr      (clr),
        .in_level (bus.go),
        .pulse    (go_p_s)
    );

    edge_pulse u_step_edge (
        .clk      (clk),
        .clr      (clr),
        .in_level (bus.step),
        .pulse    (step_p_s)
    );

    edge_pulse u_sel_edge (
        .clk      (clk),
        .clr      (clr),
        .in_level (bus.sel_next),
        .pulse    (sel_p_s)
    );

    // A syscall halts unless it is the pass-through service call, or it is
    // the syscall we just resumed from (skip lets it commit once).
    assign halt_hit_s = bus.syscall & (bus.R1 != PASS_CODE) & ~skip_r;
    assign exec_s     = (state_r == RUN) | (state_r == STEP_ONE);
    assign cpu_en_s   = exec_s & ~halt_hit_s;

    assign bus.cpu_en    = cpu_en_s;
    assign bus.cycle_en  = cpu_en_s;
    assign bus.branch_en = cpu_en_s & bus.branch_in;
    assign bus.jmp_en    = cpu_en_s & bus.jmp_in;
    assign bus.halted    = halted_r;
    assign bus.disp_sel  = disp_sel_r;
    assign bus.disp_data = disp_data_r;

    // Next-state and skip-flag logic of the run sequencer.
    always_comb begin
        state_nxt_s = state_r;
        skip_nxt_s  = skip_r;

        // The first committed cycle after leaving HALT consumes the skip.
        if (exec_s && skip_r) begin
            skip_nxt_s = 1'b0;
        end else begin
            skip_nxt_s = skip_r;
        end

        case (state_r)
            RUN: begin
                if (halt_hit_s) begin
                    state_nxt_s = HALT;
                end else if (bus.step_mode) begin
                    state_nxt_s = STEP_IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT: begin
                if (go_p_s) begin
                    state_nxt_s = bus.step_mode ? STEP_ONE : RUN;
                    skip_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            STEP_IDLE: begin
                if (!bus.step_mode) begin
                    state_nxt_s = RUN;
                end else if (step_p_s) begin
                    state_nxt_s = STEP_ONE;
                end else begin
                    state_nxt_s = STEP_IDLE;
                end
            end
            STEP_ONE: begin
                if (halt_hit_s) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = STEP_IDLE;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Sequencer state, skip flag and halted indicator registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= RUN;
            skip_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            skip_r   <= skip_nxt_s;
            halted_r <= (state_nxt_s == HALT);
        end
    end

    // Display select advance and counter value capture.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            disp_sel_r  <= SEL_CYCLE;
            disp_data_r <= 32'd0;
        end else begin
            if (sel_p_s) begin
                disp_sel_r <= sel_advance(disp_sel_r, DISP_LAST);
            end else begin
                disp_sel_r <= disp_sel_r;
            end
            case (disp_sel_r)
                SEL_CYCLE:  disp_data_r <= bus.count_cycle;
                SEL_BRANCH: disp_data_r <= bus.count_b;
                SEL_JMP:    disp_data_r <= bus.count_j;
                default:    disp_data_r <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_run_ctrl.sv
module tb_perf_run_ctrl;

    typedef struct {
        logic        sc;
        logic [31:0] r1;
        logic        br;
        logic        jp;
        logic        go;
        logic        sm;
        logic        st;
        logic        sel;
        logic        e_cpu;
        logic        e_ben;
        logic        e_jen;
        logic        e_halt;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    perf_run_ctrl_if bus();

    perf_run_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic sc, input logic [31:0] r1, input logic br,
                       input logic jp, input logic go, input logic sm,
                       input logic st, input logic sel, input logic e_cpu,
                       input logic e_ben, input logic e_jen, input logic e_halt);
        vec_t v;
        v.sc = sc; v.r1 = r1; v.br = br; v.jp = jp; v.go = go; v.sm = sm;
        v.st = st; v.sel = sel; v.e_cpu = e_cpu; v.e_ben = e_ben;
        v.e_jen = e_jen; v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    // Expected display select / data by table cycle, with sel_next pressed
    // in cycles 52,56,60,64 (pulse one cycle later, select one more, data one more).
    function automatic logic [1:0] exp_sel(input int i);
        if (i < 54) return 2'd0;
        else if (i < 58) return 2'd1;
        else if (i < 62) return 2'd2;
        else if (i < 66) return 2'd0;
        else return 2'd1;
    endfunction

    function automatic logic [31:0] exp_dd(input int i);
        if (i == 0) return 32'd0;
        else if (i < 55) return 32'd100;
        else if (i < 59) return 32'd7;
        else if (i < 63) return 32'd5;
        else if (i < 67) return 32'd100;
        else return 32'd7;
    endfunction

    task automatic drive(input logic sc, input logic [31:0] r1, input logic br,
                         input logic jp, input logic go, input logic sm,
                         input logic st, input logic sel);
        bus.syscall = sc; bus.R1 = r1; bus.branch_in = br; bus.jmp_in = jp;
        bus.go = go; bus.step_mode = sm; bus.step = st; bus.sel_next = sel;
    endtask

    initial begin
        // Test 1: plain run, branches at 1,4,7 and a jump at 8
        for (int i = 0; i < 10; i++) begin
            add(1'b0, 32'd0, (i == 1 || i == 4 || i == 7), (i == 8), 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, (i == 1 || i == 4 || i == 7), (i == 8), 1'b0);
        end
        // Test 2: pass-through syscall, then a halting one (branch masked)
        add(1'b1, 32'd34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 10
        add(1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 11
        for (int i = 12; i < 32; i++) begin
            add(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        // Test 3: resume with the syscall still presented
        add(1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 32
        add(1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // 33 go_p
        add(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 34 skip
        add(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 35
        add(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 36
        // Test 4: single-step mode
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 37 RUN
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 38 IDLE
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 39 press
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 40 step_p
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // 41 ONE
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 42
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 43
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 44 press
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 45 step_p
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 46 ONE
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 47
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 48
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 49 leave
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 50 RUN
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 51
        // Test 5: display advance presses
        for (int i = 52; i < 69; i++) begin
            add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                (i == 52 || i == 56 || i == 60 || i == 64),
                1'b1, 1'b0, 1'b0, 1'b0);
        end

        bus.count_cycle = 32'd100;
        bus.count_b     = 32'd7;
        bus.count_j     = 32'd5;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state while clr is held
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_halted", -1, 32'(bus.halted), 32'd0);
        chk("rst_sel", -1, 32'(bus.disp_sel), 32'd0);
        chk("rst_data", -1, bus.disp_data, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sc, vecs[i].r1, vecs[i].br, vecs[i].jp,
                  vecs[i].go, vecs[i].sm, vecs[i].st, vecs[i].sel);
            #1;
            chk("cpu_en", i, 32'(bus.cpu_en), 32'(vecs[i].e_cpu));
            chk("cycle_en", i, 32'(bus.cycle_en), 32'(vecs[i].e_cpu));
            chk("branch_en", i, 32'(bus.branch_en), 32'(vecs[i].e_ben));
            chk("jmp_en", i, 32'(bus.jmp_en), 32'(vecs[i].e_jen));
            chk("halted", i, 32'(bus.halted), 32'(vecs[i].e_halt));
            chk("disp_sel", i, 32'(bus.disp_sel), 32'(exp_sel(i)));
            chk("disp_data", i, bus.disp_data, exp_dd(i));
            @(negedge clk);
        end

        // Test 6: async clr while in STEP_ONE with sel_next held
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // 69: RUN -> IDLE
        #1;
        chk("t6_run_cpu", 69, 32'(bus.cpu_en), 32'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);   // 70: press step+sel
        #1;
        chk("t6_idle_cpu", 70, 32'(bus.cpu_en), 32'd0);
        @(negedge clk);
        #1;                                                      // 71: pulses
        chk("t6_pulse_cpu", 71, 32'(bus.cpu_en), 32'd0);
        chk("t6_pulse_sel", 71, 32'(bus.disp_sel), 32'd1);
        @(negedge clk);
        #1;                                                      // 72: STEP_ONE
        chk("t6_one_cpu", 72, 32'(bus.cpu_en), 32'd1);
        chk("t6_one_sel", 72, 32'(bus.disp_sel), 32'd2);
        chk("t6_one_data", 72, bus.disp_data, 32'd7);
        #1;
        clr = 1'b1;
        #1;
        chk("t6_clr_halted", 72, 32'(bus.halted), 32'd0);
        chk("t6_clr_sel", 72, 32'(bus.disp_sel), 32'd0);
        chk("t6_clr_data", 72, bus.disp_data, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // sel still held
        clr = 1'b0;
        #1;
        chk("t6_rel_cpu", 73, 32'(bus.cpu_en), 32'd1);
        chk("t6_rel_sel", 73, 32'(bus.disp_sel), 32'd0);
        chk("t6_rel_data", 73, bus.disp_data, 32'd0);
        @(negedge clk);
        #1;
        chk("t6_rel_cpu", 74, 32'(bus.cpu_en), 32'd1);
        chk("t6_rel_sel", 74, 32'(bus.disp_sel), 32'd0);
        chk("t6_rel_data", 74, bus.disp_data, 32'd100);
        @(negedge clk);
        #1;
        chk("t6_rel_cpu", 75, 32'(bus.cpu_en), 32'd1);
        chk("t6_rel_sel", 75, 32'(bus.disp_sel), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
